// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a load/store port
// sharing one MMU, with a per-transaction wait timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [6:0]  if_addr,
    input  logic [31:0] if_offset,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [6:0]  ls_addr,
    input  logic [31:0] ls_offset,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        mmu_start,
    output logic        mmu_op,
    output logic [6:0]  mmu_addr,
    output logic [31:0] mmu_offset,
    output logic [31:0] mmu_wdata,
    input  logic [31:0] mmu_rdata,
    input  logic        mmu_complete,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {GRANT_IF, GRANT_LS} grant_t;

    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    grant_t      last_grant;
    grant_t      owner;
    logic [7:0]  wait_cnt;
    logic [7:0]  cnt_next;
    logic        pick_ls;
    logic [31:0] resp_data;

    // LS wins when alone, or on a tie when IF was granted last.
    always_comb begin
        pick_ls   = ls_req && (!if_req || (last_grant == GRANT_IF));
        cnt_next  = wait_cnt + 8'd1;
        resp_data = mmu_op ? '0 : mmu_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            owner      <= GRANT_IF;
            wait_cnt   <= '0;
            mmu_start  <= 1'b0;
            mmu_op     <= 1'b0;
            mmu_addr   <= '0;
            mmu_offset <= '0;
            mmu_wdata  <= '0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            ls_done    <= 1'b0;
            ls_rdata   <= '0;
            err        <= 1'b0;
        end else begin
            mmu_start <= 1'b0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            ls_done   <= 1'b0;
            ls_rdata  <= '0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        state     <= ISSUE;
                        mmu_start <= 1'b1;
                        if (pick_ls) begin
                            owner      <= GRANT_LS;
                            last_grant <= GRANT_LS;
                            mmu_op     <= ls_we;
                            mmu_addr   <= ls_addr;
                            mmu_offset <= ls_offset;
                            mmu_wdata  <= ls_wdata;
                        end else begin
                            owner      <= GRANT_IF;
                            last_grant <= GRANT_IF;
                            mmu_op     <= 1'b0;
                            mmu_addr   <= if_addr;
                            mmu_offset <= if_offset;
                            mmu_wdata  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    // Done/rdata are registered here so they appear exactly in RESP.
                    if (mmu_complete) begin
                        state <= RESP;
                        if (owner == GRANT_LS) begin
                            ls_done  <= 1'b1;
                            ls_rdata <= resp_data;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= resp_data;
                        end
                    end else if (cnt_next == TIMEOUT) begin
                        state <= RESP;
                        err   <= 1'b1;
                        if (owner == GRANT_LS) ls_done <= 1'b1;
                        else                   if_done <= 1'b1;
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, reads, stores,
// round-robin ties, timeout, ISSUE-cycle complete and mid-WAIT reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we, mmu_complete;
    logic [6:0]  if_addr, ls_addr;
    logic [31:0] if_offset, ls_offset, ls_wdata, mmu_rdata;
    logic        if_done, ls_done, mmu_start, mmu_op, err;
    logic [31:0] if_rdata, ls_rdata, mmu_offset, mmu_wdata;
    logic [6:0]  mmu_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_offset(if_offset),
        .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_offset(ls_offset),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mmu_start(mmu_start), .mmu_op(mmu_op), .mmu_addr(mmu_addr),
        .mmu_offset(mmu_offset), .mmu_wdata(mmu_wdata), .mmu_rdata(mmu_rdata),
        .mmu_complete(mmu_complete), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From an ISSUE cycle: one WAIT cycle, complete, land in RESP.
    task automatic finish_min(input logic [31:0] data);
        mmu_rdata = data;
        step();
        mmu_complete = 1'b1;
        step();
        mmu_complete = 1'b0;
    endtask

    initial begin
        logic early;
        rst_n = 1'b0; if_req = 0; ls_req = 0; ls_we = 0; mmu_complete = 0;
        if_addr = '0; ls_addr = '0; if_offset = '0; ls_offset = '0;
        ls_wdata = '0; mmu_rdata = '0;
        step(); step();
        chk("rst_start", mmu_start, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_ls_done", ls_done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mmu_addr, 0);
        chk("rst_rdata", if_rdata | ls_rdata, 0);
        rst_n = 1'b1;

        // IF read, complete 3 cycles after start
        if_req = 1; if_addr = 7'h05; if_offset = 0;
        step();
        chk("rd_start", mmu_start, 1);
        chk("rd_op", mmu_op, 0);
        chk("rd_addr", mmu_addr, 7'h05);
        chk("rd_wdata", mmu_wdata, 0);
        mmu_rdata = 32'hDEADBEEF;
        step();
        chk("rd_start_pulse", mmu_start, 0);
        step(); step();
        mmu_complete = 1;
        step();
        chk("rd_done", if_done, 1);
        chk("rd_data", if_rdata, 32'hDEADBEEF);
        chk("rd_err", err, 0);
        chk("rd_ls_done", ls_done, 0);
        if_req = 0; mmu_complete = 0;
        step();
        chk("rd_done_clr", if_done, 0);
        chk("rd_data_clr", if_rdata, 0);

        // Round-robin tie after reset: LS, IF, LS
        rst_n = 0; step(); rst_n = 1;
        if_req = 1; if_addr = 7'h0A; ls_req = 1; ls_we = 0; ls_addr = 7'h11; ls_offset = 4;
        step();
        chk("tie1_addr", mmu_addr, 7'h11);
        chk("tie1_offset", mmu_offset, 4);
        finish_min(32'h0000_0A0A);
        chk("tie1_ls_done", ls_done, 1);
        chk("tie1_ls_data", ls_rdata, 32'h0000_0A0A);
        chk("tie1_if_done", if_done, 0);
        chk("tie1_if_data", if_rdata, 0);
        step(); step();
        chk("tie2_addr", mmu_addr, 7'h0A);
        chk("tie2_op", mmu_op, 0);
        finish_min(32'h0000_0B0B);
        chk("tie2_if_done", if_done, 1);
        chk("tie2_if_data", if_rdata, 32'h0000_0B0B);
        chk("tie2_ls_done", ls_done, 0);
        step(); step();
        chk("tie3_addr", mmu_addr, 7'h11);
        finish_min(32'h0000_0C0C);
        chk("tie3_ls_done", ls_done, 1);
        if_req = 0; ls_req = 0;
        step();

        // Store; requester fields change after latching
        ls_req = 1; ls_we = 1; ls_addr = 7'h22; ls_wdata = 32'h12345678;
        step();
        chk("st_op", mmu_op, 1);
        chk("st_wdata", mmu_wdata, 32'h12345678);
        ls_wdata = 32'hAAAA5555; ls_addr = 7'h7F; ls_we = 0;
        step();
        chk("st_wdata_w1", mmu_wdata, 32'h12345678);
        chk("st_addr_w1", mmu_addr, 7'h22);
        chk("st_op_w1", mmu_op, 1);
        step();
        chk("st_wdata_w2", mmu_wdata, 32'h12345678);
        mmu_rdata = 32'hFFFFFFFF; mmu_complete = 1;
        step();
        chk("st_done", ls_done, 1);
        chk("st_rdata", ls_rdata, 0);
        ls_req = 0; mmu_complete = 0;
        step();

        // Timeout; complete in ISSUE is ignored; req dropped mid-WAIT
        if_req = 1; if_addr = 7'h33; mmu_rdata = 32'hCAFEF00D;
        step();
        chk("to_start", mmu_start, 1);
        mmu_complete = 1;
        step();
        mmu_complete = 0;
        chk("to_issue_cmp_ignored", if_done, 0);
        if_req = 0;
        early = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            early = early | if_done | err;
        end
        chk("to_no_early_done", early, 0);
        step();
        chk("to_done", if_done, 1);
        chk("to_err", err, 1);
        chk("to_rdata", if_rdata, 0);
        step();
        chk("to_err_clr", err, 0);
        chk("to_done_clr", if_done, 0);

        // Make LS the last grant, then tie picks IF; reset in WAIT restores LS priority
        ls_req = 1; ls_we = 0; ls_addr = 7'h44;
        step();
        finish_min(32'h1);
        chk("pre_ls_done", ls_done, 1);
        ls_req = 0;
        step();
        if_req = 1; if_addr = 7'h55; ls_req = 1; ls_addr = 7'h66;
        step();
        chk("rr_if_wins", mmu_addr, 7'h55);
        step();
        rst_n = 0;
        step();
        chk("mid_rst_start", mmu_start, 0);
        chk("mid_rst_addr", mmu_addr, 0);
        chk("mid_rst_done", if_done | ls_done | err, 0);
        rst_n = 1;
        step();
        chk("post_rst_ls_wins", mmu_addr, 7'h66);
        chk("post_rst_start", mmu_start, 1);
        finish_min(32'h77);
        chk("post_rst_ls_done", ls_done, 1);
        chk("post_rst_ls_data", ls_rdata, 32'h77);
        chk("post_rst_if_done", if_done, 0);
        if_req = 0; ls_req = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
